// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding instruction-memory
// request at a time, and buffers returned words in a small queue toward IF/ID.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 2,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP_ADDR  = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_t            state;
  entry_t            q_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              room;
  logic              issue;
  logic [ADDR_W-1:0] br_pc;

  // Head is read straight from queue registers, so im_data never reaches if_*.
  assign if_valid = (count != '0);
  assign if_instr = q_mem[rd_ptr].instr;
  assign if_pc    = q_mem[rd_ptr].pc;

  assign pop   = if_valid && if_ready;
  assign push  = (state == BUSY) && im_ack && !br_taken;
  // A same-cycle pop frees a slot; nothing can be pushed before this request acks.
  assign room  = (count - CNT_W'(pop)) < DEPTH_CNT;
  assign issue = (state == IDLE) && pc_write && !br_taken && room;
  assign br_pc = {br_target[ADDR_W-1:1], 1'b0};

  // NOTE: every register here is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_ADDR;
      im_req   <= 1'b0;
      im_addr  <= RESET_ADDR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // NOTE: queue storage is reset so if_instr/if_pc read zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else if (br_taken) begin
      fetch_pc <= br_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // An ack in the redirect cycle completes the request; otherwise drain it in DROP.
      if (state != IDLE && !im_ack) begin
        state <= DROP;
      end else begin
        state  <= IDLE;
        im_req <= 1'b0;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        q_mem[wr_ptr] <= '{pc: im_addr, instr: im_data};
        wr_ptr        <= wr_ptr + 1'b1;
        fetch_pc      <= fetch_pc + STEP_ADDR;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (issue) begin
            im_req  <= 1'b1;
            im_addr <= fetch_pc;
            state   <= BUSY;
          end
        end
        BUSY, DROP: begin
          if (im_ack) begin
            im_req <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          im_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory plus a queue of
// expected IF/ID deliveries checked on every handshake.
module tb_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              pc_write;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_ack;
  logic [DATA_W-1:0] im_data;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_ready;
  logic [ADDR_W-1:0] fetch_pc;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (2),
    .PC_STEP (2),
    .RESET_PC(0)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .pc_write (pc_write),
    .br_taken (br_taken),
    .br_target(br_target),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_data  (im_data),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_ready (if_ready),
    .fetch_pc (fetch_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] issued[$];
  logic              prev_req = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              mem_en = 1'b1;
  int                lat = 1;
  int                wait_cnt = 0;

  function automatic logic [DATA_W-1:0] mem_word(logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: score a handshake that the coming edge will perform, then
  // at the falling edge log new requests and drive the memory response.
  task automatic step();
    logic [ADDR_W-1:0] e;
    logic              ack_applied;
    if (rst_n && if_valid && if_ready && !br_taken) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(if_pc), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", 32'(if_pc), 32'(e));
        check("pop_instr", 32'(if_instr), 32'(mem_word(e)));
      end
    end
    @(negedge clk);
    ack_applied = im_ack;
    if (rst_n && prev_req && im_req && !ack_applied) begin
      check("addr_stable", 32'(im_addr), 32'(prev_addr));
    end
    if (im_req && !prev_req) issued.push_back(im_addr);
    prev_req  = im_req;
    prev_addr = im_addr;
    im_ack    = 1'b0;
    if (mem_en && im_req) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        im_ack   = 1'b1;
        im_data  = mem_word(im_addr);
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic wait_req(string tag, int budget);
    int n = 0;
    while (!im_req && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(im_req), 32'd1);
  endtask

  task automatic wait_empty(string tag, int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    br_taken = 1'b0;
    pc_write = 1'b0;
    if_ready = 1'b0;
    im_ack   = 1'b0;
    mem_en   = 1'b1;
    lat      = 1;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    issued.delete();
  endtask

  initial begin
    int n;
    int n_iss;
    rst_n     = 1'b1;
    pc_write  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    im_ack    = 1'b0;
    im_data   = '0;
    if_ready  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_im_req", 32'(im_req), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", 32'(if_instr), 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_fetch_pc", 32'(fetch_pc), 32'd0);

    // Sequential fetch, 1-cycle memory, IF/ID always ready.
    do_reset();
    pc_write = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(2 * i));
    wait_empty("seq_drain", 40);
    if_ready = 1'b0;
    pc_write = 1'b0;
    check("seq_issue_count", 32'(issued.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < issued.size(); i++) begin
      check("seq_im_addr", 32'(issued[i]), 32'(2 * i));
    end

    // Backpressure: exactly two entries fill, then no further requests.
    do_reset();
    pc_write = 1'b1;
    repeat (10) step();
    check("bp_issue_count", 32'(issued.size()), 32'd2);
    check("bp_im_req_idle", 32'(im_req), 32'd0);
    check("bp_if_valid", 32'(if_valid), 32'd1);
    check("bp_head_pc", 32'(if_pc), 32'h00);
    check("bp_fetch_pc", 32'(fetch_pc), 32'h04);
    lat = 3;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    if_ready = 1'b1;
    wait_empty("bp_drain", 40);
    if_ready = 1'b0;
    check("bp_resume_addr", 32'(issued.size() >= 3 ? issued[2] : 8'hFF), 32'h04);

    // Redirect while the 0x06 request is outstanding (3-cycle memory).
    check("br_busy_req", 32'(im_req), 32'd1);
    check("br_busy_addr", 32'(im_addr), 32'h06);
    br_taken  = 1'b1;
    br_target = 8'h41;
    exp_q.push_back(8'h40);
    step();
    br_taken = 1'b0;
    check("br_drop_req_held", 32'(im_req), 32'd1);
    check("br_drop_addr_held", 32'(im_addr), 32'h06);
    check("br_fetch_pc", 32'(fetch_pc), 32'h40);
    check("br_flush", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    wait_empty("br_drain", 40);
    if_ready = 1'b0;
    pc_write = 1'b0;
    check("br_next_addr", 32'(issued.size() >= 5 ? issued[4] : 8'hFF), 32'h40);

    // Redirect in the same cycle as the memory ack.
    do_reset();
    mem_en   = 1'b0;
    pc_write = 1'b1;
    wait_req("ackbr_req", 10);
    check("ackbr_addr0", 32'(im_addr), 32'h00);
    im_ack    = 1'b1;
    im_data   = 16'hDEAD;
    br_taken  = 1'b1;
    br_target = 8'h80;
    step();
    br_taken = 1'b0;
    check("ackbr_empty", 32'(if_valid), 32'd0);
    check("ackbr_req_low", 32'(im_req), 32'd0);
    check("ackbr_fetch_pc", 32'(fetch_pc), 32'h80);
    step();
    check("ackbr_reissue", 32'(im_req), 32'd1);
    check("ackbr_target", 32'(im_addr), 32'h80);
    mem_en = 1'b1;
    exp_q.push_back(8'h80);
    if_ready = 1'b1;
    wait_empty("ackbr_drain", 20);
    if_ready = 1'b0;
    pc_write = 1'b0;

    // PC wrap at 0xFE with pc_write dropped during the outstanding fetch.
    do_reset();
    br_taken  = 1'b1;
    br_target = 8'hFF;
    step();
    br_taken = 1'b0;
    check("wrap_fetch_pc_even", 32'(fetch_pc), 32'hFE);
    lat      = 3;
    pc_write = 1'b1;
    wait_req("wrap_req", 10);
    check("wrap_addr", 32'(im_addr), 32'hFE);
    pc_write = 1'b0;
    exp_q.push_back(8'hFE);
    n_iss = issued.size();
    repeat (8) step();
    check("wrap_delivered", 32'(if_valid), 32'd1);
    check("wrap_head_pc", 32'(if_pc), 32'hFE);
    check("wrap_fetch_pc", 32'(fetch_pc), 32'h00);
    check("stall_no_req", 32'(im_req), 32'd0);
    check("stall_no_issue", 32'(issued.size()), 32'(n_iss));
    if_ready = 1'b1;
    wait_empty("wrap_drain", 10);
    if_ready = 1'b0;
    pc_write = 1'b1;
    wait_req("wrap_resume_req", 10);
    check("wrap_resume_addr", 32'(im_addr), 32'h00);

    // Asynchronous reset while a request is outstanding and the queue is occupied.
    n = 0;
    while (!(if_valid && im_req) && n < 20) begin
      step();
      n++;
    end
    check("prereset_state", 32'({if_valid, im_req}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("areset_im_req", 32'(im_req), 32'd0);
    check("areset_if_valid", 32'(if_valid), 32'd0);
    check("areset_im_addr", 32'(im_addr), 32'h00);
    check("areset_fetch_pc", 32'(fetch_pc), 32'h00);
    mem_en   = 1'b0;
    pc_write = 1'b0;
    im_ack   = 1'b1;
    step();
    im_ack = 1'b1;
    step();
    rst_n  = 1'b1;
    im_ack = 1'b1;
    step();
    check("stray_ack_no_push", 32'(if_valid), 32'd0);
    check("stray_ack_fetch_pc", 32'(fetch_pc), 32'h00);
    check("stray_ack_no_req", 32'(im_req), 32'd0);
    issued.delete();
    mem_en   = 1'b1;
    lat      = 1;
    pc_write = 1'b1;
    if_ready = 1'b1;
    exp_q.push_back(8'h00);
    wait_req("post_reset_req", 10);
    check("post_reset_addr", 32'(im_addr), 32'h00);
    wait_empty("post_reset_drain", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and drives instruction-memory requests. It buffers returned instructions in a small prefetch queue and presents {instruction, PC} to the IF/ID pipeline register through a valid/ready handshake. It sits directly upstream of IF/ID, replacing the loose PC/adder/IM wiring. It also accepts branch redirects from the EX-stage branch logic and PC-write stalls from hazard detection.

Parameters:
ADDR_W, 8, PC / instruction-memory address width (byte address)
DATA_W, 16, instruction width
DEPTH, 2, prefetch queue entries (power of two, >=2)
PC_STEP, 2, PC increment per instruction
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
pc_write  input  1  hazard-unit PCWrite; 0 = issue no new fetch requests
br_taken  input  1  one-cycle redirect pulse from branch logic (PCSRC)
br_target  input  ADDR_W  redirect address, sampled when br_taken=1
im_req  output  1  fetch request to instruction memory
im_addr  output  ADDR_W  fetch address, stable while im_req=1
im_ack  input  1  one-cycle pulse: im_data valid, request complete
im_data  input  DATA_W  returned instruction
if_valid  output  1  queue head valid toward IF/ID
if_instr  output  DATA_W  queue head instruction
if_pc  output  ADDR_W  address of queue head instruction
if_ready  input  1  IF/ID accepts (IFID_Write); pop when if_valid & if_ready
fetch_pc  output  ADDR_W  address of the next request to be issued (debug)

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; queue empty; state IDLE.
  - im_req=0, im_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
  - Reset mid-request abandons the request; an im_ack arriving during or after reset while in IDLE is ignored.
- Outputs: if_valid/if_instr/if_pc come from registered queue head only. There is no combinational path from im_data to if_*. Minimum latency is ack cycle + 1.
- Single outstanding request max. im_req stays high with a constant im_addr until im_ack.
- FSM states:
  - IDLE: issue a request when pc_write=1, br_taken=0, and occupancy < DEPTH. The request sets im_req=1, im_addr=fetch_pc, and moves to BUSY next cycle.
  - BUSY: wait for im_ack. On ack: push {fetch_pc, im_data}; fetch_pc += PC_STEP (mod 2^ADDR_W, so 0xFE wraps to 0x00); return to IDLE. Back-to-back issue in the cycle after an ack is allowed.
  - DROP: a redirect hit while BUSY. Hold im_req/im_addr until im_ack, discard the data, and go to IDLE. fetch_pc already holds the target.
- Occupancy counts only queue entries. A request is issued only if, at ack time, a free slot is guaranteed: occupancy + 1 <= DEPTH, counting a same-cycle pop as freeing a slot.
- Redirect (br_taken=1) has highest priority:
  - Queue flushed in the same edge; if_valid=0 next cycle.
  - fetch_pc = br_target with bit0 forced to 0.
  - BUSY goes to DROP; IDLE stays IDLE with no request that cycle.
  - Redirect in the same cycle as im_ack: the acked data is discarded and fetch_pc is not incremented.
  - Redirect in the same cycle as a pop: the pop is irrelevant because the queue clears.
  - Redirect while in DROP: update fetch_pc and stay in DROP.
- pc_write=0 blocks only new issues. An outstanding request completes and is pushed normally.
- Push and pop in the same cycle: occupancy is unchanged. When full, if_ready=0 holds the head stable.
- Queue pointers wrap modulo DEPTH. Queue entries are not cleared on pop (values are don't-care when invalid).

Test Plan:
- Sequential fetch, memory with 1-cycle ack latency, if_ready=1:
  - if_pc sequence 0x00, 0x02, 0x04, 0x06, each with the matching im_data.
  - im_addr increments by 2; no duplicates or gaps.
- Backpressure with if_ready=0 for 10 cycles:
  - Exactly DEPTH=2 entries fill (PC 0x00, 0x02), then im_req stays 0.
  - On release, those pop in order and fetching resumes at 0x04.
- Redirect while BUSY: br_taken with br_target=0x41 during an outstanding request at 0x06 and 3-cycle ack latency.
  - The 0x06 data never appears on if_*.
  - The next im_addr is 0x40, and the first if_pc after it is 0x40.
- Redirect in the same cycle as im_ack: the acked word is discarded, the queue is empty next cycle, and the next request targets br_target.
- Wrap and stall: with fetch_pc=0xFE and pc_write=0 asserted during the outstanding fetch, the 0xFE word is delivered. No new im_req until pc_write=1, then im_addr=0x00.
- Async reset mid-request: assert reset low between edges while BUSY.
  - im_req and if_valid drop immediately; a stray im_ack during reset is ignored.
  - After release, the first im_addr is 0x00.
